// File: rtl/matmul_seq_engine.sv
// Sequential N x N matrix multiplier: one multiply-accumulate per cycle,
// one write-back cycle per output element, operands snapshotted at start.
module matmul_seq_engine #(
  parameter int unsigned ORDER    = 2,
  parameter int unsigned BITWIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic                                 enable,
  input  logic [0:ORDER*ORDER*BITWIDTH-1]      matAarg,
  input  logic [0:ORDER*ORDER*BITWIDTH-1]      matBarg,
  output logic [0:ORDER*ORDER*BITWIDTH-1]      matCarg,
  output logic [15:0]                          rdy
);

  localparam int unsigned N  = ORDER;
  localparam int unsigned W  = BITWIDTH;
  localparam int unsigned NN = N * N;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

  state_t          state_q, state_n;
  logic [IW-1:0]   i_q, i_n, j_q, j_n, k_q, k_n;
  logic [W-1:0]    acc_q, acc_n;
  logic [W-1:0]    a_q [NN];
  logic [W-1:0]    a_n [NN];
  logic [W-1:0]    b_q [NN];
  logic [W-1:0]    b_n [NN];
  logic [W-1:0]    c_q [NN];
  logic [W-1:0]    c_n [NN];
  logic [W-1:0]    a_in [NN];
  logic [W-1:0]    b_in [NN];
  logic [W-1:0]    a_el, b_el;
  logic            busy_q, busy_n, done_q, done_n;
  int unsigned     a_idx, b_idx, c_idx;

  // Unpack operand buses and pack the result buffer onto the output bus
  for (genvar g = 0; g < int'(NN); g++) begin : g_pack
    assign a_in[g]              = matAarg[W*g +: W];
    assign b_in[g]              = matBarg[W*g +: W];
    assign matCarg[W*g +: W]    = c_q[g];
  end

  assign rdy = {14'd0, busy_q, done_q};

  // State, index, accumulator, snapshot and result registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int unsigned e = 0; e < NN; e++) begin
        a_q[e] <= '0;
        b_q[e] <= '0;
        c_q[e] <= '0;
      end
    end else begin
      state_q <= state_n;
      i_q     <= i_n;
      j_q     <= j_n;
      k_q     <= k_n;
      acc_q   <= acc_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      a_q     <= a_n;
      b_q     <= b_n;
      c_q     <= c_n;
    end
  end

  // Next-state, datapath and status logic
  always_comb begin
    state_n = state_q;
    i_n     = i_q;
    j_n     = j_q;
    k_n     = k_q;
    acc_n   = acc_q;
    a_n     = a_q;
    b_n     = b_q;
    c_n     = c_q;
    a_el    = '0;
    b_el    = '0;
    a_idx   = 32'(i_q) * N + 32'(k_q);
    b_idx   = 32'(k_q) * N + 32'(j_q);
    c_idx   = 32'(i_q) * N + 32'(j_q);

    // Operand fetch from the snapshots as a mux over all elements
    for (int unsigned e = 0; e < NN; e++) begin
      if (e == a_idx) a_el = a_q[e];
      if (e == b_idx) b_el = b_q[e];
    end

    case (state_q)
      IDLE: begin
        if (enable) begin
          a_n     = a_in;
          b_n     = b_in;
          for (int unsigned e = 0; e < NN; e++) c_n[e] = '0;
          acc_n   = '0;
          i_n     = '0;
          j_n     = '0;
          k_n     = '0;
          state_n = MAC;
        end
      end
      MAC: begin
        if (!enable) begin
          state_n = IDLE;
        end else begin
          acc_n = acc_q + W'(a_el * b_el);
          if (k_q == IW'(N - 1)) state_n = WRITE;
          else                   k_n     = k_q + IW'(1);
        end
      end
      WRITE: begin
        if (!enable) begin
          state_n = IDLE;
        end else begin
          for (int unsigned e = 0; e < NN; e++) begin
            if (e == c_idx) c_n[e] = acc_q;
          end
          acc_n = '0;
          k_n   = '0;
          if (j_q == IW'(N - 1)) begin
            j_n = '0;
            if (i_q == IW'(N - 1)) begin
              i_n     = '0;
              state_n = DONE;
            end else begin
              i_n     = i_q + IW'(1);
              state_n = MAC;
            end
          end else begin
            j_n     = j_q + IW'(1);
            state_n = MAC;
          end
        end
      end
      DONE: begin
        if (!enable) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n == MAC) || (state_n == WRITE);
    done_n = (state_n == DONE);
  end

endmodule

// File: tb/tb_matmul_seq_engine.sv
// Directed bench for matmul_seq_engine at N=2, W=32.
module tb_matmul_seq_engine;

  localparam int unsigned N = 2;
  localparam int unsigned W = 32;
  localparam int unsigned BW = N * N * W;

  logic          clk = 1'b0;
  logic          resetn;
  logic          enable;
  logic [0:BW-1] matAarg, matBarg, matCarg;
  logic [15:0]   rdy;

  int checks = 0;
  int errors = 0;

  matmul_seq_engine #(.ORDER(N), .BITWIDTH(W)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .enable  (enable),
    .matAarg (matAarg),
    .matBarg (matBarg),
    .matCarg (matCarg),
    .rdy     (rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a [4];
    logic [31:0] b [4];
    logic [31:0] c [4];
    int          zero_a_at;   // edge after E0 at which A is cleared, 0 = never
  } vec_t;

  vec_t vecs [5];

  function automatic logic [0:BW-1] pack4(input logic [31:0] x [4]);
    return {x[0], x[1], x[2], x[3]};
  endfunction

  function automatic logic [31:0] elem(input logic [0:BW-1] bus, input int e);
    logic [0:BW-1] t;
    t = bus << (W * e);
    return t[0:31];
  endfunction

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_c(input string name, input logic [31:0] exp [4]);
    for (int e = 0; e < 4; e++)
      chk($sformatf("%s C[%0d]", name, e), BW'(elem(matCarg, e)), BW'(exp[e]));
  endtask

  // Start edge, then 12 busy/compute edges; checks busy through E0+11, done at E0+12
  task automatic run_vec(input vec_t v);
    int busy_bad;
    busy_bad = 0;
    matAarg = pack4(v.a);
    matBarg = pack4(v.b);
    enable  = 1'b1;
    step();                                   // E0
    if (rdy !== 16'h0002) busy_bad++;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == v.zero_a_at) matAarg = '0;
      if (k < 12 && rdy !== 16'h0002) busy_bad++;
    end
    chk({v.name, " busy edges"}, BW'(busy_bad), BW'(0));
    chk({v.name, " rdy done"}, BW'(rdy), BW'(16'h0001));
    chk_c(v.name, v.c);
  endtask

  initial begin
    vec_t v;
    logic [0:BW-1] held;
    int bad;

    vecs[0] = '{"basic", '{1, 2, 3, 4}, '{5, 6, 7, 8}, '{19, 22, 43, 50}, 0};
    vecs[1] = '{"wrap", '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
                '{2, 2, 2, 2},
                '{32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFC}, 0};
    vecs[2] = '{"snapshot", '{1, 2, 3, 4}, '{5, 6, 7, 8}, '{19, 22, 43, 50}, 3};
    vecs[3] = '{"mixed", '{2, 3, 4, 5}, '{6, 7, 8, 9}, '{36, 41, 64, 73}, 0};
    vecs[4] = '{"hi16", '{32'h10000, 0, 0, 32'h10000}, '{32'h10000, 1, 1, 32'h10000},
                '{0, 32'h10000, 32'h10000, 0}, 0};

    resetn  = 1'b0;
    enable  = 1'b0;
    matAarg = '0;
    matBarg = '0;
    #2;
    chk("reset rdy", BW'(rdy), BW'(16'h0000));
    chk("reset C", matCarg, '0);
    step();
    step();
    resetn = 1'b1;
    step();
    chk("idle rdy", BW'(rdy), BW'(16'h0000));

    // Table-driven computations, each followed by a release to IDLE
    for (int t = 0; t < 5; t++) begin
      run_vec(vecs[t]);
      held = matCarg;
      enable = 1'b0;
      step();
      chk({vecs[t].name, " release rdy"}, BW'(rdy), BW'(16'h0000));
      chk({vecs[t].name, " release C"}, matCarg, held);
    end

    // Abort after E0+5: C[0][0] written, C[0][1] not yet
    v = vecs[0];
    matAarg = pack4(v.a);
    matBarg = pack4(v.b);
    enable  = 1'b1;
    step();
    for (int k = 1; k <= 5; k++) step();
    enable = 1'b0;
    step();
    chk("abort rdy", BW'(rdy), BW'(16'h0000));
    chk("abort C00", BW'(elem(matCarg, 0)), BW'(19));
    chk("abort C01", BW'(elem(matCarg, 1)), BW'(0));
    chk("abort C10", BW'(elem(matCarg, 2)), BW'(0));
    step();
    chk("abort idle", BW'(rdy), BW'(16'h0000));
    run_vec(v);
    enable = 1'b0;
    step();

    // Async reset mid-computation
    v = vecs[3];
    matAarg = pack4(v.a);
    matBarg = pack4(v.b);
    enable  = 1'b1;
    step();
    for (int k = 1; k <= 7; k++) step();
    chk("pre-reset C00", BW'(elem(matCarg, 0)), BW'(36));
    #2 resetn = 1'b0;
    enable = 1'b0;
    #1;
    chk("async rdy", BW'(rdy), BW'(16'h0000));
    chk("async C", matCarg, '0);
    #1 resetn = 1'b1;
    step();
    step();
    chk("post-reset rdy", BW'(rdy), BW'(16'h0000));
    chk("post-reset C", matCarg, '0);
    run_vec(vecs[4]);

    // Done hold for 20 edges with enable high, then release
    held = matCarg;
    bad  = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (rdy !== 16'h0001 || matCarg !== held) bad++;
    end
    chk("hold stable", BW'(bad), BW'(0));
    enable = 1'b0;
    step();
    chk("hold release rdy", BW'(rdy), BW'(16'h0000));
    chk("hold release C", matCarg, held);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
